// File: rtl/seq_div_16x8.sv
// Sequential 16/8 unsigned restoring divider, one quotient bit per cycle, valid/ready on both sides.
// Optional re-multiplication self-check enabled by defining DIV_MULT_CHECK_EN.
module seq_div_16x8 #(
    parameter logic [15:0] DZ_QUOT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_by_zero,
    output logic        busy,
    output logic        check_err
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready is high only in IDLE, out_valid only in DONE, and neither depends on the other side.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [15:0] shf_q;    // dividend bits still to be consumed, MSB first
    logic [7:0]  dvs_q;
    logic [8:0]  prem_q;
    logic [15:0] quo_w;
    logic [4:0]  step_q;

    logic [8:0]  rem_sh;
    logic        sub_ok;
    logic [8:0]  rem_nx;
    logic [15:0] quo_nx;
    logic        last_step;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_CALC);
    assign last_step = (step_q == 5'd15);

    // prem_q[8] set would mean the shifted value exceeds any 8-bit divisor, so it forces a subtract.
    always_comb begin
        rem_sh = {prem_q[7:0], shf_q[15]};
        sub_ok = prem_q[8] | (rem_sh >= {1'b0, dvs_q});
        rem_nx = sub_ok ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
        quo_nx = {quo_w[14:0], sub_ok};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            shf_q       <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            quo_w       <= '0;
            step_q      <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        dvs_q <= divisor;
                        if (divisor == 8'd0) begin
                            quotient    <= DZ_QUOT;
                            remainder   <= dividend[7:0];
                            div_by_zero <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            shf_q  <= dividend;
                            prem_q <= '0;
                            quo_w  <= '0;
                            step_q <= '0;
                            state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    prem_q <= rem_nx;
                    shf_q  <= {shf_q[14:0], 1'b0};
                    quo_w  <= quo_nx;
                    step_q <= step_q + 5'd1;
                    if (last_step) begin
                        quotient    <= quo_nx;
                        remainder   <= rem_nx[7:0];
                        div_by_zero <= 1'b0;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DIV_MULT_CHECK_EN
    logic [15:0] dvd_q;
    logic [23:0] recon;

    assign recon = (quo_nx * dvs_q) + {16'd0, rem_nx[7:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q     <= '0;
            check_err <= 1'b0;
        end else begin
            if (state == S_IDLE && in_valid) begin
                dvd_q     <= dividend;
                check_err <= 1'b0;
            end else if (state == S_CALC && last_step) begin
                check_err <= (recon != {8'd0, dvd_q});
            end
        end
    end
`else
    assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_div_16x8.sv
// Self-checking bench for seq_div_16x8: directed cases from the requirements, then a random sweep
// compared against an arithmetic reference model through an expected-result queue.
module tb_seq_div_16x8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        in_ready, out_valid, div_by_zero, busy, check_err;
    logic [15:0] quotient;
    logic [7:0]  remainder;

    int passed = 0;
    int total = 0;
    logic [25:0] exp_q[$];
    logic [25:0] last_res = '0;

    seq_div_16x8 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
        .busy(busy), .check_err(check_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Result packing: {quotient, remainder, div_by_zero, check_err}
    function automatic logic [25:0] model(input logic [15:0] a, input logic [7:0] b);
        int q, r;
        if (b == 8'd0) return {16'hFFFF, a[7:0], 1'b1, 1'b0};
        q = int'(a) / int'(b);
        r = int'(a) % int'(b);
        return {q[15:0], r[7:0], 1'b0, 1'b0};
    endfunction

    function automatic logic [25:0] res_now();
        return {quotient, remainder, div_by_zero, check_err};
    endfunction

    // Called at #1 after a rising edge with the DUT idle; returns at #1 after the edge raising out_valid.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input string tag);
        int cyc;
        int bad;
        exp_q.push_back(model(a, b));
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        cyc = 0;
        bad = 0;
        while (out_valid !== 1'b1 && cyc < 40) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_latency"}, cyc, (b == 8'd0) ? 0 : 16);
        chk({tag, "_calc_flags"}, bad, 0);
        chk({tag, "_done_flags"}, {busy, in_ready, out_valid}, 3'b001);
        last_res = exp_q.pop_front();
        chk({tag, "_result"}, res_now(), last_res);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_released"}, {out_valid, in_ready}, 2'b01);
        chk({tag, "_retained"}, res_now(), last_res);
    endtask

    initial begin
        int ov_seen;
        logic [15:0] ra;
        logic [7:0]  rb;

        // Reset: outputs cleared, operands offered during reset are not taken
        #1;
        chk("reset_state", {res_now(), out_valid, busy, in_ready}, {26'd0, 3'b001});
        dividend = 16'd1234;
        divisor  = 8'd5;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_holds", {out_valid, busy, in_ready}, 3'b001);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First accept on the first edge after reset release
        run_op(16'd1000, 8'd7, "d1000_7");

        // Hold with out_ready=0; a second offer must be ignored
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_valid = 1'b1;
                dividend = 16'd5;
                divisor  = 8'd1;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk("hold_result", res_now(), last_res);
            chk("hold_flags", {out_valid, in_ready}, 2'b10);
        end
        consume("d1000_7");
        ov_seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) ov_seen++;
        end
        chk("no_queued_op", ov_seen, 0);

        run_op(16'd65535, 8'd255, "d65535_255");
        consume("d65535_255");
        out_ready = 1'b1;  // out_ready high outside DONE must not matter
        run_op(16'd5, 8'd10, "d5_10");
        consume("d5_10");
        run_op(16'd100, 8'd0, "d100_0");
        consume("d100_0");

        // Reset in the middle of a calculation
        dividend = 16'd40000;
        divisor  = 8'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_calc_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_state", {res_now(), out_valid, busy, in_ready}, {26'd0, 3'b001});
        @(posedge clk);
        #1;
        rst = 1'b0;
        ov_seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) ov_seen++;
        end
        chk("abort_no_valid", ov_seen, 0);
        chk("abort_outputs", res_now(), 26'd0);
        last_res = '0;
        run_op(16'd40000, 8'd3, "d40000_3");
        consume("d40000_3");

        // Random sweep
        for (int n = 0; n < 2500; n++) begin
            case ($urandom_range(0, 9))
                0:       rb = 8'd0;
                1, 2:    rb = 8'($urandom_range(1, 15));
                3:       rb = 8'd255;
                default: rb = 8'($urandom_range(1, 255));
            endcase
            case ($urandom_range(0, 15))
                0:       ra = 16'd0;
                1:       ra = 16'hFFFF;
                2:       ra = 16'($urandom_range(0, 255));
                default: ra = 16'($urandom);
            endcase
            out_ready = 1'($urandom_range(0, 1));
            run_op(ra, rb, "rand");
            consume("rand");
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
